// File: rtl/icache_arb_pkg.sv
// icache_arb_pkg: shared state encoding and AXI burst constants for the icache read arbiter
package icache_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a registered priority pointer
module rr_arbiter2
  import icache_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);
  logic prio_q;
  assign gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_q);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | prio_q);
  // Priority moves to the requester that just lost (inverse of the winner)
  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= 1'b0;
    else if (accept_i) prio_q <= gnt_o[0];
  end
endmodule

// File: rtl/icache_read_arbiter.sv
// icache_read_arbiter: shares the single-outstanding icache read port between fetch (m0) and prefetch (m1)
module icache_read_arbiter
  import icache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [1:0]        m0_arburst,
  input  logic [2:0]        m0_arsize,
  input  logic [7:0]        m0_arlen,
  output logic              m0_arready,
  input  logic              m0_rready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [1:0]        m1_arburst,
  input  logic [2:0]        m1_arsize,
  input  logic [7:0]        m1_arlen,
  output logic              m1_arready,
  input  logic              m1_rready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [1:0]        s_arburst,
  output logic [2:0]        s_arsize,
  output logic [7:0]        s_arlen,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic              owner,
  output logic              busy,
  output logic              len_err
);
  arb_state_e        state_q, state_d;
  logic              owner_q, len_err_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [1:0]        arburst_q;
  logic [2:0]        arsize_q;
  logic [7:0]        arlen_q, beats_q;
  logic [1:0]        gnt;
  logic              idle, in_addr, in_data, accept, hs, win, to_m0, to_m1;
  assign idle    = state_q == ARB_IDLE;
  assign in_addr = state_q == ARB_ADDR;
  assign in_data = state_q == ARB_DATA;
  assign accept  = idle & (m0_arvalid | m1_arvalid);
  assign win     = gnt[1];
  assign hs      = in_data & s_rvalid & s_rready;
  assign to_m0   = in_data & ~owner_q;
  assign to_m1   = in_data & owner_q;
  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({m1_arvalid, m0_arvalid}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );
  // Next state: grant -> address handshake -> data beats until rlast
  always_comb begin
    state_d = idle    ? (accept ? ARB_ADDR : ARB_IDLE) :
              in_addr ? (s_arready ? ARB_DATA : ARB_ADDR) :
                        ((hs & s_rlast) ? ARB_IDLE : ARB_DATA);
  end
  // State, latched request fields, beat counter and sticky length-mismatch flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= 1'b0;
      araddr_q  <= '0;
      arburst_q <= '0;
      arsize_q  <= '0;
      arlen_q   <= '0;
      beats_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q   <= win;
        araddr_q  <= win ? m1_araddr : m0_araddr;
        arburst_q <= win ? m1_arburst : m0_arburst;
        arsize_q  <= win ? m1_arsize : m0_arsize;
        arlen_q   <= win ? m1_arlen : m0_arlen;
      end
      if (in_addr & s_arready) beats_q <= '0;
      else if (hs) beats_q <= beats_q + 8'd1;
      if (hs & (s_rlast ? (beats_q != arlen_q) : (beats_q == arlen_q))) len_err_q <= 1'b1;
    end
  end
  assign m0_arready = idle & gnt[0];
  assign m1_arready = idle & gnt[1];
  assign s_arvalid  = in_addr;
  assign s_araddr   = araddr_q;
  assign s_arburst  = arburst_q;
  assign s_arsize   = arsize_q;
  assign s_arlen    = arlen_q;
  assign s_rready   = in_data & (owner_q ? m1_rready : m0_rready);
  assign m0_rvalid  = to_m0 & s_rvalid;
  assign m0_rlast   = to_m0 & s_rlast;
  assign m0_rdata   = to_m0 ? s_rdata : '0;
  assign m1_rvalid  = to_m1 & s_rvalid;
  assign m1_rlast   = to_m1 & s_rlast;
  assign m1_rdata   = to_m1 ? s_rdata : '0;
  assign owner      = owner_q;
  assign busy       = ~idle;
  assign len_err    = len_err_q;
endmodule

// File: tb/tb_icache_read_arbiter.sv
// tb_icache_read_arbiter: transaction-level checks of grant order, steering, stalls, length errors and reset
module tb_icache_read_arbiter;
  import icache_arb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_arvalid = 0, m1_arvalid = 0, m0_rready = 0, m1_rready = 0;
  logic [31:0] m0_araddr = 0, m1_araddr = 0;
  logic [1:0] m0_arburst = 0, m1_arburst = 0;
  logic [2:0] m0_arsize = 0, m1_arsize = 0;
  logic [7:0] m0_arlen = 0, m1_arlen = 0;
  logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_arvalid, s_rready, owner, busy, len_err;
  logic [31:0] s_araddr;
  logic [1:0] s_arburst;
  logic [2:0] s_arsize;
  logic [7:0] s_arlen;
  logic s_arready = 0, s_rvalid = 0, s_rlast = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0] arr, rv, rl;
  logic [31:0] rd [2];
  int vec = 0, err = 0;
  logic ref_prio = 1'b0, ref_err = 1'b0;
  assign arr = {m1_arready, m0_arready};
  assign rv = {m1_rvalid, m0_rvalid};
  assign rl = {m1_rlast, m0_rlast};
  assign rd[0] = m0_rdata;
  assign rd[1] = m1_rdata;
  always #5 clk = ~clk;
  icache_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arburst(m0_arburst), .m0_arsize(m0_arsize),
    .m0_arlen(m0_arlen), .m0_arready(m0_arready), .m0_rready(m0_rready), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arburst(m1_arburst), .m1_arsize(m1_arsize),
    .m1_arlen(m1_arlen), .m1_arready(m1_arready), .m1_rready(m1_rready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arburst(s_arburst), .s_arsize(s_arsize),
    .s_arlen(s_arlen), .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rready(s_rready), .owner(owner), .busy(busy), .len_err(len_err)
  );
  // One full transaction; winner and length-error outcome come from the round-robin / beat-count rules
  task automatic run_txn(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] dbase, input int nb, input int stall, input logic [7:0] len);
    logic w;
    logic [1:0] oh;
    logic [31:0] a [2];
    logic [31:0] d;
    a[0] = a0;
    a[1] = a1;
    w = (v0 & v1) ? ref_prio : v1;
    oh = w ? 2'b10 : 2'b01;
    m0_arvalid = v0; m0_araddr = a0; m0_arburst = BURST_INCR; m0_arsize = 3'd2; m0_arlen = len;
    m1_arvalid = v1; m1_araddr = a1; m1_arburst = BURST_WRAP; m1_arsize = 3'd3; m1_arlen = len;
    m0_rready = 1; m1_rready = 1; s_arready = 0; s_rvalid = 0; s_rlast = 0;
    @(negedge clk);
    vec++;
    if (arr !== oh || busy !== 1'b0) begin
      err++; $display("FAIL grant: arready=%b busy=%b expected arready=%b busy=0", arr, busy, oh);
    end
    @(posedge clk); #1;
    s_arready = 1;
    @(negedge clk);
    vec++;
    if (s_arvalid !== 1'b1 || s_araddr !== a[w] || s_arlen !== len || owner !== w || arr !== 2'b00 || busy !== 1'b1) begin
      err++; $display("FAIL addr: arvalid=%b addr=%h len=%0d owner=%b arready=%b busy=%b expected 1 %h %0d %b 00 1",
                      s_arvalid, s_araddr, s_arlen, owner, arr, busy, a[w], len, w);
    end
    vec++;
    if (s_arburst !== (w ? BURST_WRAP : BURST_INCR) || s_arsize !== (w ? 3'd3 : 3'd2)) begin
      err++; $display("FAIL fields: burst=%b size=%0d expected %b %0d", s_arburst, s_arsize,
                      w ? BURST_WRAP : BURST_INCR, w ? 3 : 2);
    end
    @(posedge clk); #1;
    s_arready = 0;
    for (int i = 0; i < nb; i++) begin
      d = dbase + i;
      s_rvalid = 1; s_rdata = d; s_rlast = (i == nb - 1);
      for (int k = 0; k < ((i == 0) ? stall : 0); k++) begin
        if (w) m1_rready = 0; else m0_rready = 0;
        @(negedge clk);
        vec++;
        if (s_rready !== 1'b0 || rv !== oh || rd[w] !== d || rd[!w] !== 32'h0 || arr !== 2'b00) begin
          err++; $display("FAIL stall: s_rready=%b rvalid=%b rdata=%h other=%h arready=%b expected 0 %b %h 0 00",
                          s_rready, rv, rd[w], rd[!w], arr, oh, d);
        end
        @(posedge clk); #1;
      end
      m0_rready = 1; m1_rready = 1;
      @(negedge clk);
      vec++;
      if (s_rready !== 1'b1 || rv !== oh || rl !== (s_rlast ? oh : 2'b00) || rd[w] !== d || rd[!w] !== 32'h0 || busy !== 1'b1) begin
        err++; $display("FAIL beat%0d: s_rready=%b rvalid=%b rlast=%b rdata=%h other=%h busy=%b expected 1 %b %b %h 0 1",
                        i, s_rready, rv, rl, rd[w], rd[!w], busy, oh, s_rlast ? oh : 2'b00, d);
      end
      if ((i == nb - 1) ? (i != int'(len)) : (i == int'(len))) ref_err = 1'b1;
      @(posedge clk); #1;
    end
    s_rvalid = 0; s_rlast = 0;
    ref_prio = ~w;
    #1;
    vec++;
    if (busy !== 1'b0 || len_err !== ref_err) begin
      err++; $display("FAIL done: busy=%b len_err=%b expected 0 %b", busy, len_err, ref_err);
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    @(posedge clk); #1;
    vec++;
    if ({s_arvalid, s_rready, arr, rv, rl, owner, busy, len_err} !== 11'h0 ||
        s_araddr !== 0 || s_arburst !== 0 || s_arsize !== 0 || s_arlen !== 0 || rd[0] !== 0 || rd[1] !== 0) begin
      err++; $display("FAIL reset: ctl=%b addr=%h len=%0d rdata=%h/%h expected all 0",
                      {s_arvalid, s_rready, arr, rv, rl, owner, busy, len_err}, s_araddr, s_arlen, rd[0], rd[1]);
    end
    rst_n = 1;
    ref_prio = 0; ref_err = 0;
  endtask
  task automatic test_single();
    run_txn(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0, 8'd0);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_txn(1, 1, 32'h4, 32'h8, $urandom, 1, 0, 8'd0);
  endtask
  task automatic test_stall();
    run_txn(1, 1, 32'h40, 32'h80, $urandom, 1, 4, 8'd0);
    run_txn(1, 1, 32'h44, 32'h84, $urandom, 2, 4, 8'd1);
  endtask
  task automatic test_burst();
    run_txn(1, 0, 32'h100, 32'h0, $urandom, 4, 0, 8'd3);
    run_txn(1, 0, 32'h200, 32'h0, $urandom, 2, 0, 8'd3);
    run_txn(0, 1, 32'h0, 32'h300, $urandom, 1, 0, 8'd0);
  endtask
  task automatic test_random();
    logic v0, v1;
    int ln;
    for (int i = 0; i < 12; i++) begin
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      ln = $urandom_range(0, 3);
      run_txn(v0, v1, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : ln + 1, $urandom_range(0, 2), 8'(ln));
    end
  endtask
  task automatic test_reset_mid();
    m0_arvalid = 1; m1_arvalid = 0; m0_araddr = 32'h500; m0_arlen = 8'd3; m0_rready = 1;
    @(posedge clk); #1;
    m0_arvalid = 0; s_arready = 1;
    @(posedge clk); #1;
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h1234_5678; s_rlast = 0;
    @(negedge clk);
    vec++;
    if (m0_rvalid !== 1'b1 || busy !== 1'b1) begin
      err++; $display("FAIL pre_reset: m0_rvalid=%b busy=%b expected 1 1", m0_rvalid, busy);
    end
    rst_n = 0;
    @(posedge clk); #1;
    vec++;
    if ({s_arvalid, s_rready, arr, rv, rl, owner, busy, len_err} !== 11'h0 || s_araddr !== 0 || s_arlen !== 0 || rd[0] !== 0) begin
      err++; $display("FAIL mid_reset: ctl=%b addr=%h len=%0d rdata=%h expected all 0",
                      {s_arvalid, s_rready, arr, rv, rl, owner, busy, len_err}, s_araddr, s_arlen, rd[0]);
    end
    rst_n = 1; s_rvalid = 0;
    ref_prio = 0; ref_err = 0;
    run_txn(1, 1, 32'h600, 32'h700, $urandom, 1, 0, 8'd0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_burst();
    test_random();
    test_reset_mid();
    m0_arvalid = 0; m1_arvalid = 0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
